// File: rtl/stream_width_upsizer_if.sv
// Narrow-in / wide-out stream bundle for the width upsizer.
// slave  : the upsizer side (consumes narrow beats, produces wide words).
// master : the environment side (FIFO read port + downstream consumer).
interface stream_width_upsizer_if #(
    parameter int DataWidth = 4,
    parameter int Ratio     = 4
);
    // narrow input side (FIFO read port)
    logic                         in_valid;
    logic [DataWidth-1:0]         in_data;
    logic                         in_last;
    logic                         in_ready;

    // wide output side
    logic                         out_valid;
    logic [DataWidth*Ratio-1:0]   out_data;
    logic [Ratio-1:0]             out_keep;
    logic                         out_last;
    logic                         out_ready;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_keep, out_last
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_keep, out_last
    );
endinterface

// File: rtl/stream_width_upsizer.sv
// Packs Ratio consecutive DataWidth beats into one wide word, lane 0 first.
// A packet ending early on in_last produces a partial word with a keep mask.
// One accumulator plus one output register; when the output register is busy
// and a packet closes early, the accumulator parks in CLOSED until it drains.
module stream_width_upsizer #(
    parameter int DataWidth = 4,
    parameter int Ratio     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    stream_width_upsizer_if.slave  bus
);

    localparam int             CW       = (Ratio > 1) ? $clog2(Ratio) : 1;
    localparam int             OW       = DataWidth * Ratio;
    localparam logic [CW-1:0]  LastLane = CW'(Ratio - 1);

    // FILLING / CLOSED are encoded by closed_q
    localparam logic [0:0]     FILLING  = 1'b0;
    localparam logic [0:0]     CLOSED   = 1'b1;

    generate
        if (Ratio < 2) begin : g_bad_ratio
            $error("stream_width_upsizer: Ratio must be >= 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [Ratio-1:0][DataWidth-1:0] acc_q, acc_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [0:0]                      closed_q, closed_d;
    logic                            last_q, last_d;

    logic                            out_valid_q, out_valid_d;
    logic [OW-1:0]                   out_data_q, out_data_d;
    logic [Ratio-1:0]                out_keep_q, out_keep_d;
    logic                            out_last_q, out_last_d;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic out_free;
    logic in_ready;
    logic accept;
    logic complete;
    logic load_in;
    logic load_closed;
    logic close_word;
    logic load;

    assign out_free    = !out_valid_q || bus.out_ready;
    // Only the final lane needs the downstream slot, so only it looks at out_ready.
    assign in_ready    = !reset && (closed_q == FILLING) &&
                         ((cnt_q != LastLane) || out_free);
    assign accept      = bus.in_valid && in_ready;
    assign complete    = accept && ((cnt_q == LastLane) || bus.in_last);
    assign load_in     = complete && out_free;
    // Early close with the output busy: park the word until the slot frees.
    assign close_word  = complete && !out_free;
    assign load_closed = (closed_q == CLOSED) && out_free;
    assign load        = load_in || load_closed;

    // ------------------------------------------------------------------
    // Word assembly: in FILLING the live beat fills lane cnt; in CLOSED the
    // word is exactly the cnt stored lanes. Unused lanes read as zero.
    // ------------------------------------------------------------------
    logic [Ratio-1:0]                lane_keep;
    logic [Ratio-1:0][DataWidth-1:0] lane_data;
    logic                            word_last;

    for (genvar i = 0; i < Ratio; i++) begin : g_lane
        localparam logic [CW-1:0] Idx = CW'(i);
        logic stored;
        logic live;
        assign stored       = (Idx < cnt_q);
        assign live         = (closed_q == FILLING) && (Idx == cnt_q);
        assign lane_keep[i] = stored || live;
        assign lane_data[i] = stored ? acc_q[i] :
                              live   ? bus.in_data : '0;
    end

    assign word_last = (closed_q == CLOSED) ? last_q : bus.in_last;

    // Accumulator next state: lane write, lane count and FILLING/CLOSED
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        closed_d = closed_q;
        last_d   = last_q;
        if (accept) begin
            acc_d[cnt_q] = bus.in_data;
        end
        if (load) begin
            cnt_d    = '0;
            closed_d = FILLING;
        end else if (close_word) begin
            cnt_d    = cnt_q + 1'b1;
            closed_d = CLOSED;
            last_d   = bus.in_last;
        end else if (accept) begin
            cnt_d    = cnt_q + 1'b1;
        end
    end

    // Output register next state: load wins over drain so out_valid stays up
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = lane_data;
            out_keep_d  = lane_keep;
            out_last_d  = word_last;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset; reset discards any partial word
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            closed_q    <= FILLING;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            closed_q    <= closed_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_keep  = out_keep_q;
    assign bus.out_last  = out_last_q;

    // A stalled word must stay put until the consumer takes it
    a_out_hold: assert property (@(posedge clk) disable iff (reset)
        (out_valid_q && !bus.out_ready) |=>
        (out_valid_q && $stable(out_data_q) && $stable(out_keep_q) && $stable(out_last_q)));

    // CLOSED always holds at least the closing beat
    a_closed_nonempty: assert property (@(posedge clk) disable iff (reset)
        (closed_q == CLOSED) |-> (cnt_q != '0));

endmodule

// File: tb/tb_stream_width_upsizer.sv
// Scoreboard bench for stream_width_upsizer (DataWidth=4, Ratio=4).
// The driver feeds a packet-level reference model on every accepted beat;
// a separate monitor pops expected words whenever a wide word is taken.
module tb_stream_width_upsizer;

    localparam int DW = 4;
    localparam int R  = 4;

    logic clk;
    logic reset;

    stream_width_upsizer_if #(.DataWidth(DW), .Ratio(R)) bif ();

    stream_width_upsizer #(.DataWidth(DW), .Ratio(R)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    typedef struct {
        logic [15:0] d;
        logic [3:0]  k;
        logic        l;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // reference model: current partial word as plain arithmetic
    int          m_n   = 0;
    int          m_val = 0;
    logic [3:0]  m_k   = '0;
    int          model_beats = 0;
    int          mon_beats   = 0;

    logic rand_mode = 1'b0;
    logic ready_cmd = 1'b0;
    logic rnd_rdy   = 1'b0;

    assign bif.out_ready = rand_mode ? rnd_rdy : ready_cmd;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) rnd_rdy <= ($urandom_range(0, 3) != 0);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (tests=%0d failed=%0d)", tests, fails);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        m_n   = 0;
        m_val = 0;
        m_k   = '0;
    endtask

    // beat i of a word contributes d * 16^i; a word closes after R beats or on last
    task automatic model_accept(input logic [3:0] d, input logic l);
        m_val = m_val + int'(d) * (1 << (4 * m_n));
        m_k   = m_k | 4'(1 << m_n);
        m_n++;
        if (m_n == R || l) begin
            exp_q.push_back('{d: 16'(m_val), k: m_k, l: l});
            model_beats += m_n;
            model_clear();
        end
    endtask

    task automatic send(input logic [3:0] d, input logic l, output int waited);
        bit ok;
        ok     = 1'b0;
        waited = 0;
        bif.in_valid = 1'b1;
        bif.in_data  = d;
        bif.in_last  = l;
        while (!ok && waited <= 1000) begin
            @(negedge clk);
            if (bif.in_ready) ok = 1'b1;
            else waited++;
        end
        if (ok) model_accept(d, l);
        else chk("send_timeout", 32'(waited), 32'd0);
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
        bif.in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("reset_in_ready", 32'(bif.in_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        exp_q.delete();
        chk("post_reset_out_valid", 32'(bif.out_valid), 32'd0);
    endtask

    // monitor: pop/compare on each taken word, and check stall stability
    initial begin : monitor
        logic        hold;
        logic [15:0] hd;
        logic [3:0]  hk;
        logic        hl;
        exp_t        e;
        hold = 1'b0;
        hd = '0; hk = '0; hl = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold = 1'b0;
            end else begin
                if (hold)
                    chk("hold_stable",
                        32'({bif.out_valid, bif.out_data, bif.out_keep, bif.out_last}),
                        32'({1'b1, hd, hk, hl}));
                if (bif.out_valid && bif.out_ready) begin
                    mon_beats += $countones(bif.out_keep);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word",
                            32'({1'b1, bif.out_data, bif.out_keep, bif.out_last}), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word{data,keep,last}",
                            32'({bif.out_data, bif.out_keep, bif.out_last}),
                            32'({e.d, e.k, e.l}));
                    end
                end
                hold = bif.out_valid && !bif.out_ready;
                hd   = bif.out_data;
                hk   = bif.out_keep;
                hl   = bif.out_last;
            end
        end
    end

    initial begin : stim
        int         w;
        logic [3:0] c;
        int         n;

        bif.in_valid = 1'b0;
        bif.in_data  = '0;
        bif.in_last  = 1'b0;
        ready_cmd    = 1'b0;
        reset        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(bif.in_ready),  32'd0);
        chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
        chk("rst_out_data",  32'(bif.out_data),  32'd0);
        chk("rst_out_keep",  32'(bif.out_keep),  32'd0);
        chk("rst_out_last",  32'(bif.out_last),  32'd0);
        reset = 1'b0;
        model_clear();
        #1;
        chk("idle_in_ready", 32'(bif.in_ready), 32'd1);

        // full word, one-cycle latency
        ready_cmd = 1'b1;
        send(4'd1, 1'b0, w); send(4'd2, 1'b0, w); send(4'd3, 1'b0, w);
        chk("full_pre_valid", 32'(bif.out_valid), 32'd0);
        send(4'd4, 1'b0, w);
        chk("full_latency_valid", 32'(bif.out_valid), 32'd1);
        chk("full_data", 32'({bif.out_data, bif.out_keep, bif.out_last}), 32'({16'h4321, 4'hF, 1'b0}));

        // partial packet, next beat restarts at lane 0
        send(4'd5, 1'b0, w); send(4'd6, 1'b1, w);
        chk("partial_data", 32'({bif.out_data, bif.out_keep, bif.out_last}), 32'({16'h0065, 4'h3, 1'b1}));
        send(4'd7, 1'b0, w); send(4'd8, 1'b1, w);
        chk("restart_lane0", 32'({bif.out_data, bif.out_keep, bif.out_last}), 32'({16'h0087, 4'h3, 1'b1}));

        // backpressure
        idle(2);
        ready_cmd = 1'b0;
        for (int i = 0; i < 7; i++) send(4'(i), 1'b0, w);
        bif.in_valid = 1'b1;
        bif.in_data  = 4'd7;
        @(negedge clk);
        chk("bp_in_ready_low", 32'(bif.in_ready), 32'd0);
        chk("bp_held_word", 32'({bif.out_valid, bif.out_data}), 32'({1'b1, 16'h3210}));
        idle(2);
        chk("bp_still_low", 32'(bif.in_ready), 32'd0);
        ready_cmd = 1'b1;
        send(4'd7, 1'b0, w);
        chk("bp_release_no_wait", 32'(w), 32'd0);
        chk("bp_second_word", 32'({bif.out_valid, bif.out_data}), 32'({1'b1, 16'h7654}));

        // closed state
        idle(2);
        ready_cmd = 1'b0;
        send(4'd1, 1'b0, w); send(4'd2, 1'b0, w); send(4'd3, 1'b0, w); send(4'd4, 1'b0, w);
        send(4'd9, 1'b1, w);
        chk("closed_accepted_no_wait", 32'(w), 32'd0);
        chk("closed_in_ready", 32'(bif.in_ready), 32'd0);
        idle(1);
        chk("closed_in_ready_2", 32'(bif.in_ready), 32'd0);
        ready_cmd = 1'b1;
        @(negedge clk);
        chk("closed_xfer_cycle_in_ready", 32'(bif.in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("closed_after_in_ready", 32'(bif.in_ready), 32'd1);
        chk("closed_word", 32'({bif.out_valid, bif.out_data, bif.out_keep, bif.out_last}),
            32'({1'b1, 16'h0009, 4'h1, 1'b1}));

        // streaming at full rate
        idle(2);
        c = 4'd0;
        for (int i = 0; i < 64; i++) begin
            send(c, 1'b0, w);
            chk("stream_no_stall", 32'(w), 32'd0);
            if (i == 3) chk("stream_first", 32'(bif.out_data), 32'h3210);
            if (i == 15) chk("stream_fourth", 32'(bif.out_data), 32'hFEDC);
            c = c + 4'd1;
        end

        // reset mid-word
        idle(2);
        chk("pre_reset_queue_empty", 32'(exp_q.size()), 32'd0);
        send(4'd1, 1'b0, w); send(4'd2, 1'b0, w);
        do_reset();
        send(4'd3, 1'b0, w); send(4'd4, 1'b0, w); send(4'd5, 1'b0, w); send(4'd6, 1'b0, w);
        chk("reset_first_word", 32'({bif.out_valid, bif.out_data, bif.out_keep}),
            32'({1'b1, 16'h6543, 4'hF}));

        // randomized traffic with random backpressure and packet ends
        idle(2);
        rand_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
            send(4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0), w);
        end
        send(4'($urandom_range(0, 15)), 1'b1, w);
        rand_mode = 1'b0;
        ready_cmd = 1'b1;

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            idle(1);
            n++;
        end
        idle(2);
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("beat_conservation", 32'(mon_beats), 32'(model_beats));
        chk("final_out_valid", 32'(bif.out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stream_width_upsizer.md
Name: stream_width_upsizer

Overview:
- Read-domain consumer placed directly after async_fifo.
- Accepts narrow DataWidth beats from the FIFO read port (valid/ready) and packs Ratio consecutive beats into one wide word for the downstream datapath.
- A packet may end early on in_last; the block then emits a partial word with a per-lane keep mask.
- Single clock domain: the FIFO read clock.

Parameters:
DataWidth  4  width of one input beat, bits
Ratio      4  input beats per output word; legal range >= 2; elaboration error otherwise

Ports:
clk        input   1                  clock; same clock as the FIFO read side
reset      input   1                  synchronous, active-high reset
in_valid   input   1                  input beat valid; driven by FIFO rvalid
in_data    input   DataWidth          input beat data; driven by FIFO rdata
in_last    input   1                  beat is the final beat of a packet
in_ready   output  1                  block accepts beat; drives FIFO rready
out_valid  output  1                  wide word valid
out_data   output  DataWidth*Ratio    packed word; lane i = bits [i*DataWidth +: DataWidth]
out_keep   output  Ratio              bit i set = lane i holds a valid beat
out_last   output  1                  word closes a packet
out_ready  input   1                  downstream accepts word

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Handshakes:
  - A transfer occurs on a rising clk edge with valid && ready.
  - out_valid, once high, must not drop, and out_data/keep/last must hold until out_ready.
- Storage: an accumulator (Ratio lanes, lane count `cnt` of width $clog2(Ratio), `closed` flag) plus one output register.
- Packing order:
  - The first accepted beat of a word goes to lane 0 (LSBs), the next to lane 1, and so on.
  - Unfilled lanes are 0 in out_data and 0 in out_keep.
- out_free = !out_valid || out_ready.
- in_ready = !reset && !closed && (cnt < Ratio-1 || out_free).
  - Combinational path from out_ready to in_ready is allowed only for the final lane.
- On an accepted beat:
  - Completing beat (cnt == Ratio-1, or in_last):
    - If out_free: the word moves to the output register at the same edge. out_valid = 1 next cycle. out_keep = lanes 0..cnt. out_last = in_last. cnt <= 0.
    - If not out_free (possible only with in_last, cnt < Ratio-1): the beat is stored, closed <= 1, and the last flag is latched.
  - Otherwise: the beat is stored in lane cnt, cnt <= cnt+1.
- Closed accumulator (state CLOSED): on the first cycle with out_free, the word transfers to the output register, cnt <= 0, closed <= 0. in_ready stays low for that whole cycle.
- States:
  - FILLING (closed=0) -> CLOSED on in_last accepted while the output is occupied.
  - CLOSED -> FILLING on transfer.
- Output register: cleared (out_valid <= 0) when out_ready is high and no new word is loaded the same edge. Load and drain on the same edge: the new word replaces the old one, and out_valid stays 1.
- Latency: 1 cycle from the completing input beat to out_valid.
- Throughput: with out_ready held high, in_ready stays high continuously, giving one output word per Ratio input beats.
- Reset values: out_valid 0, out_data 0, out_keep 0, out_last 0, cnt 0, closed 0. in_ready is 0 while reset is high.
- Reset mid-word: accumulated lanes and any held output word are discarded. Nothing partial is emitted after reset.
- in_last on lane Ratio-1: a full word with out_keep all-ones and out_last 1.
- in_last on lane 0: out_keep = 1, out_last 1.
- The block never creates or drops beats: the sum of popcount(out_keep) equals the number of accepted input beats.

Test Plan:
- Full word: DataWidth=4, Ratio=4, out_ready=1; beats 1,2,3,4 with in_last=0 -> one word out_data=0x4321, out_keep=0xF, out_last=0; out_valid one cycle after beat 4.
- Partial packet: beats 5, then 6 with in_last=1 -> out_data=0x0065, out_keep=0x3, out_last=1. The next beat 7 lands in lane 0 of a new word.
- Backpressure: out_ready=0; feed 0..7 continuously.
  - First word 0x3210 is held stable.
  - in_ready drops when beat 7 is presented (cnt=3).
  - Raise out_ready -> 0x3210 then 0x7654 delivered, no beat lost or duplicated.
- Closed state: out_ready=0 with a word held; beat 9 with in_last=1 at cnt=0 -> accepted, in_ready goes low. Raise out_ready -> next word out_data=0x0009, out_keep=0x1, out_last=1; in_ready returns high the cycle after the transfer.
- Streaming: in_valid held high with an incrementing 4-bit counter (as driven from the FIFO), out_ready=1 -> in_ready constantly high; words 0x3210, 0x7654, 0xBA98, 0xFEDC, 0x3210... appear every 4 cycles.
- Reset mid-word: accept beats 1,2, assert reset for 1 cycle, then send 3,4,5,6 -> out_valid never asserts for the 1,2 data; the first word is 0x6543, out_keep=0xF.
